mips_cpu_lsu: RTL and testbench
===============================

# mips_cpu_lsu

Load/store unit sitting between the execute stage and the Avalon memory bus, directly upstream of the register-file write port. Accepts one memory instruction at a time and runs a waitrequest-honouring Avalon read or write. For loads, it hands the regfile a bus word in the lane layout the regfile's partial-load logic expects. For stores, it generates byteenable and lane-shifted write data.

## Interface
- `MAX_WAIT`, default 0: waitrequest cycles tolerated before abort; 0 means unlimited.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request strobe; accepted only when `ready`=1.
- `opcode` in 6: MIPS primary opcode of the memory instruction.
- `addr` in 32: effective address (base + offset).
- `storedata` in 32: rt value for stores.
- `ready` out 1: idle and able to accept `start`.
- `done` out 1: one-cycle completion pulse.
- `regwrite` out 1: `done` & (request was a load) & no error.
- `load_data` out 32: data to regfile `writedata`; valid while `done`=1.
- `load_opcode` out 6: latched opcode, forwarded to the regfile `opcode` input.
- `addr_error` out 1: misaligned access; valid with `done`.
- `bus_error` out 1: `MAX_WAIT` timeout; valid with `done`.
- `avm_address` out 32: word-aligned bus address (`addr`[31:2], 2'b00).
- `avm_read` out 1: Avalon read request.
- `avm_write` out 1: Avalon write request.
- `avm_writedata` out 32: Avalon write data.
- `avm_byteenable` out 4: Avalon byte enables.
- `avm_readdata` in 32: Avalon read data.
- `avm_waitrequest` in 1: Avalon stall.

## Operation
- Loads: lb 100000, lh 100001, lwl 100010, lw 100011, lbu 100100, lhu 100101, lwr 100110. Stores: sb 101000, sh 101001, sw 101011.
- `start` with any other opcode, or while `ready`=0, is ignored: no state change, no `done`.
- FSM states: IDLE, BUS, DONE.
  - IDLE -> BUS on an accepted `start`. The unit latches opcode, addr, storedata and computes byteenable and writedata.
  - BUS: `avm_read` or `avm_write` is held with address, data and byteenable stable.
  - BUS -> DONE on the first cycle with `avm_waitrequest`=0. Read data is captured on that edge.
  - DONE -> IDLE unconditionally.
- Load lane rules, little-endian, byte offset o = addr[1:0]:
  - lb/lbu: `load_data`[7:0] = byte o. Upper bits are zero; the regfile does the extension.
  - lh/lhu: `load_data`[15:0] = halfword at o (o ∈ {0,2}).
  - lw/lwl/lwr: `load_data` = raw `avm_readdata`. The regfile merges using the address low bits.
  - Loads always use `avm_byteenable` = 4'b1111.
- Store lane rules:
  - sb: byteenable = 1 << o, writedata = {4{storedata[7:0]}}.
  - sh: byteenable = 4'b0011 << o, writedata = {2{storedata[15:0]}}.
  - sw: byteenable = 4'b1111, writedata = storedata.
- `MAX_WAIT`≠0: a counter runs in BUS. If waitrequest is still high after `MAX_WAIT` cycles, the request drops and the FSM moves to DONE with `bus_error`=1 and `regwrite`=0.

## Timing
- Reset values: FSM in IDLE; `ready`=1; all other outputs 0, including `avm_*` strobes, `load_data`, `load_opcode` and both error flags.
- `start` accepted at edge N. `avm_read`/`avm_write` high from cycle N+1.
- Zero-wait slave: DONE in cycle N+2, `ready` again in cycle N+3. Minimum 3 cycles per access; each waitrequest cycle adds 1.
- `done`, `regwrite`, `load_data` and the error flags are registered and high for exactly one cycle. The regfile writes them on its negedge within that cycle.
- `ready`=0 from N+1 until DONE exits. `start` in the DONE cycle is ignored.
- `reset_n` low during BUS: the request is dropped at the next edge, with no `done`.
- `avm_*` outputs are driven only from registers, never combinationally from `start`.

## Configuration
- `MIPS_LSU_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are lh/lhu/sh with addr[0]=1, and lw/sw with addr[1:0]≠0.
  - A misaligned access goes IDLE -> DONE directly, with no bus cycle, `addr_error`=1 and `regwrite`=0.
- Undefined:
  - No check; `addr_error` is tied 0.
  - For lh/lhu/sh, addr[0] is ignored.
  - For lw/sw, addr[1:0] is ignored.

## Structure
- The shared package `mips_cpu_pkg` holds the opcode localparams (OP_LB … OP_SW) and the LSU state enum `lsu_state_t`.
- One sub-module, `mips_cpu_lsu_lane`, is purely combinational. It maps opcode plus offset to byteenable, shifted writedata and extracted load lanes.

## Test plan
- lw addr 0x100, slave returns 0xDEADBEEF with 2 waitrequest cycles -> `done` and `regwrite` 5 cycles after `start`, `load_data`=0xDEADBEEF.
- lb addr 0x203, readdata 0x80112233 -> `avm_address`=0x200, `load_data`=0x00000080, `load_opcode`=100000.
- sh addr 0x12, storedata 0x0000ABCD -> `avm_byteenable`=1100, `avm_writedata`=0xABCDABCD, `regwrite`=0.
- With `MIPS_LSU_ALIGN_CHECK_EN`, lw addr 0x101 -> no `avm_read`, `addr_error`=1 two cycles after `start`, `regwrite`=0.
- `MAX_WAIT`=4, waitrequest stuck high -> `avm_read` drops and `bus_error`=1 after 4 wait cycles.
- `reset_n` low mid-BUS -> `avm_read`=0 and `ready`=1 next cycle, no `done`. A `start` while busy is ignored.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: memory-instruction opcodes, LSU state encoding and the Avalon request payload.
package mips_cpu_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = DATA_W / 8;

    localparam logic [OPCODE_W-1:0] OP_LB  = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_LH  = 6'b100001;
    localparam logic [OPCODE_W-1:0] OP_LWL = 6'b100010;
    localparam logic [OPCODE_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_LBU = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_LHU = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_LWR = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_SB  = 6'b101000;
    localparam logic [OPCODE_W-1:0] OP_SH  = 6'b101001;
    localparam logic [OPCODE_W-1:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } avm_req_t;

endpackage

// File: rtl/mips_cpu_lsu_lane.sv
// Combinational lane mapper: opcode + byte offset -> byteenable, replicated store data, extracted load lanes.
// MIPS_LSU_ALIGN_CHECK_EN enables misalignment detection; otherwise low address bits are ignored for halfword/word.
module mips_cpu_lsu_lane
    import mips_cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          offset,
    input  logic [DATA_W-1:0]   storedata,
    input  logic [DATA_W-1:0]   readdata,
    output logic                is_load_c,
    output logic                is_store_c,
    output logic                misaligned_c,
    output logic [BE_W-1:0]     byteenable_c,
    output logic [DATA_W-1:0]   writedata_c,
    output logic [DATA_W-1:0]   load_data_c
);

    logic [1:0] half_off;

    always_comb begin
        half_off     = {offset[1], 1'b0};
        is_load_c    = 1'b0;
        is_store_c   = 1'b0;
        misaligned_c = 1'b0;
        byteenable_c = '0;
        writedata_c  = '0;
        load_data_c  = '0;
        unique case (opcode)
            OP_LB, OP_LBU: begin
                is_load_c    = 1'b1;
                byteenable_c = 4'b1111;
                load_data_c  = {24'd0, readdata[{offset, 3'b000} +: 8]};
            end
            OP_LH, OP_LHU: begin
                is_load_c    = 1'b1;
                byteenable_c = 4'b1111;
                load_data_c  = {16'd0, readdata[{half_off, 3'b000} +: 16]};
`ifdef MIPS_LSU_ALIGN_CHECK_EN
                misaligned_c = offset[0];
`endif
            end
            OP_LW: begin
                is_load_c    = 1'b1;
                byteenable_c = 4'b1111;
                load_data_c  = readdata;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
                misaligned_c = |offset;
`endif
            end
            // Unaligned word loads hand the raw word to the regfile, which merges by address.
            OP_LWL, OP_LWR: begin
                is_load_c    = 1'b1;
                byteenable_c = 4'b1111;
                load_data_c  = readdata;
            end
            OP_SB: begin
                is_store_c   = 1'b1;
                byteenable_c = 4'b0001 << offset;
                writedata_c  = {4{storedata[7:0]}};
            end
            OP_SH: begin
                is_store_c   = 1'b1;
                byteenable_c = 4'b0011 << half_off;
                writedata_c  = {2{storedata[15:0]}};
`ifdef MIPS_LSU_ALIGN_CHECK_EN
                misaligned_c = offset[0];
`endif
            end
            OP_SW: begin
                is_store_c   = 1'b1;
                byteenable_c = 4'b1111;
                writedata_c  = storedata;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
                misaligned_c = |offset;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one memory instruction at a time over a waitrequest-honouring Avalon master port.
// Optional MIPS_LSU_ALIGN_CHECK_EN (in mips_cpu_lsu_lane) flags misaligned accesses without a bus cycle.
module mips_cpu_lsu
    import mips_cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   addr,
    input  logic [DATA_W-1:0]   storedata,
    output logic                ready,
    output logic                done,
    output logic                regwrite,
    output logic [DATA_W-1:0]   load_data,
    output logic [OPCODE_W-1:0] load_opcode,
    output logic                addr_error,
    output logic                bus_error,
    output logic [DATA_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [BE_W-1:0]     avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    lsu_state_t          state_q, state_d;
    avm_req_t            avm_req_q, avm_req_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [1:0]          off_q, off_d;
    logic                is_load_q, is_load_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                regwrite_q, regwrite_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                addr_error_q, addr_error_d;
    logic                bus_error_q, bus_error_d;

    logic [OPCODE_W-1:0] lane_op;
    logic [1:0]          lane_off;
    logic                lane_is_load, lane_is_store, lane_misaligned;
    logic [BE_W-1:0]     lane_be;
    logic [DATA_W-1:0]   lane_wdata, lane_rdata;

    // In IDLE the lane mapper sees the incoming request; afterwards it sees the latched one.
    assign lane_op  = (state_q == LSU_IDLE) ? opcode    : op_q;
    assign lane_off = (state_q == LSU_IDLE) ? addr[1:0] : off_q;

    mips_cpu_lsu_lane u_lane (
        .opcode       (lane_op),
        .offset       (lane_off),
        .storedata    (storedata),
        .readdata     (avm_readdata),
        .is_load_c    (lane_is_load),
        .is_store_c   (lane_is_store),
        .misaligned_c (lane_misaligned),
        .byteenable_c (lane_be),
        .writedata_c  (lane_wdata),
        .load_data_c  (lane_rdata)
    );

    always_comb begin
        state_d      = state_q;
        avm_req_d    = avm_req_q;
        op_d         = op_q;
        off_d        = off_q;
        is_load_d    = is_load_q;
        wait_cnt_d   = wait_cnt_q;
        done_d       = 1'b0;
        regwrite_d   = 1'b0;
        load_data_d  = '0;
        addr_error_d = 1'b0;
        bus_error_d  = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (start && (lane_is_load || lane_is_store)) begin
                    op_d       = opcode;
                    off_d      = addr[1:0];
                    is_load_d  = lane_is_load;
                    wait_cnt_d = '0;
                    if (lane_misaligned) begin
                        state_d      = LSU_DONE;
                        done_d       = 1'b1;
                        addr_error_d = 1'b1;
                    end else begin
                        state_d              = LSU_BUS;
                        avm_req_d.address    = {addr[31:2], 2'b00};
                        avm_req_d.read       = lane_is_load;
                        avm_req_d.write      = lane_is_store;
                        avm_req_d.writedata  = lane_wdata;
                        avm_req_d.byteenable = lane_be;
                    end
                end
            end
            LSU_BUS: begin
                if (!avm_waitrequest) begin
                    state_d         = LSU_DONE;
                    avm_req_d.read  = 1'b0;
                    avm_req_d.write = 1'b0;
                    done_d          = 1'b1;
                    regwrite_d      = is_load_q;
                    if (is_load_q) begin
                        load_data_d = lane_rdata;
                    end
                end else if (MAX_WAIT != 0) begin
                    // Abort once the slave has stalled for MAX_WAIT consecutive cycles.
                    if (wait_cnt_q == CNT_LAST) begin
                        state_d         = LSU_DONE;
                        avm_req_d.read  = 1'b0;
                        avm_req_d.write = 1'b0;
                        done_d          = 1'b1;
                        bus_error_d     = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
        ready_d = (state_d == LSU_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= LSU_IDLE;
            avm_req_q    <= '0;
            op_q         <= '0;
            off_q        <= '0;
            is_load_q    <= 1'b0;
            wait_cnt_q   <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            regwrite_q   <= 1'b0;
            load_data_q  <= '0;
            addr_error_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            avm_req_q    <= avm_req_d;
            op_q         <= op_d;
            off_q        <= off_d;
            is_load_q    <= is_load_d;
            wait_cnt_q   <= wait_cnt_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            regwrite_q   <= regwrite_d;
            load_data_q  <= load_data_d;
            addr_error_q <= addr_error_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign ready          = ready_q;
    assign done           = done_q;
    assign regwrite       = regwrite_q;
    assign load_data      = load_data_q;
    assign load_opcode    = op_q;
    assign addr_error     = addr_error_q;
    assign bus_error      = bus_error_q;
    assign avm_address    = avm_req_q.address;
    assign avm_read       = avm_req_q.read;
    assign avm_write      = avm_req_q.write;
    assign avm_writedata  = avm_req_q.writedata;
    assign avm_byteenable = avm_req_q.byteenable;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu (MAX_WAIT=4) with a configurable-latency Avalon slave.
module tb_mips_cpu_lsu;
    import mips_cpu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  opc;
        logic        rw;
        logic        aerr;
        logic        berr;
        int          lat;
        int          strobes;
        int          t0;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset_n, start, ready, done, regwrite, addr_error, bus_error;
    logic [5:0]  opcode, load_opcode;
    logic [31:0] addr, storedata, load_data, avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wait_left = 0;
    int   strobe_cnt = 0;
    bit   prev_strobe = 1'b0;
    exp_t exp_q[$];
    bus_t bus_q[$];

    mips_cpu_lsu #(.MAX_WAIT(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .storedata       (storedata),
        .ready           (ready),
        .done            (done),
        .regwrite        (regwrite),
        .load_data       (load_data),
        .load_opcode     (load_opcode),
        .addr_error      (addr_error),
        .bus_error       (bus_error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] data, input logic [5:0] opc, input logic rw,
                                input logic aerr, input logic berr, input int lat, input int strobes);
        return '{data: data, opc: opc, rw: rw, aerr: aerr, berr: berr, lat: lat, strobes: strobes, t0: 0};
    endfunction

    function automatic bus_t mkb(input logic [31:0] a, input logic rd, input logic wr,
                                 input logic [3:0] be, input logic [31:0] wd);
        return '{addr: a, rd: rd, wr: wr, be: be, wd: wd};
    endfunction

    // Avalon slave: stalls the configured number of cycles on each request.
    always @(negedge clk) begin
        if (avm_read || avm_write) begin
            if (wait_left > 0) begin
                avm_waitrequest = 1'b1;
                wait_left--;
            end else begin
                avm_waitrequest = 1'b0;
            end
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    // Monitor: checks each new bus request and each completion against the queues.
    always @(negedge clk) begin
        exp_t e;
        bus_t b;
        if (avm_read || avm_write) begin
            if (!prev_strobe) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_request", 32'(1), 32'(0));
                end else begin
                    b = bus_q.pop_front();
                    chk("avm_address", avm_address, b.addr);
                    chk("avm_read", 32'(avm_read), 32'(b.rd));
                    chk("avm_write", 32'(avm_write), 32'(b.wr));
                    chk("avm_byteenable", 32'(avm_byteenable), 32'(b.be));
                    chk("avm_writedata", avm_writedata, b.wd);
                end
            end
            strobe_cnt++;
        end
        prev_strobe = avm_read || avm_write;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("load_data", load_data, e.data);
                chk("load_opcode", 32'(load_opcode), 32'(e.opc));
                chk("regwrite", 32'(regwrite), 32'(e.rw));
                chk("addr_error", 32'(addr_error), 32'(e.aerr));
                chk("bus_error", 32'(bus_error), 32'(e.berr));
                chk("done_latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
                chk("ready_low_in_done", 32'(ready), 32'(0));
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int waits, input bit hold,
                         input bit has_bus, input bus_t b, input exp_t e);
        exp_t ee;
        bit   got;
        @(negedge clk);
        wait_left    = waits;
        avm_readdata = rd;
        opcode       = op;
        addr         = a;
        storedata    = sd;
        start        = 1'b1;
        strobe_cnt   = 0;
        ee           = e;
        ee.t0        = cyc;
        exp_q.push_back(ee);
        if (has_bus) bus_q.push_back(b);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'(1));
        if (!got) begin
            exp_q.delete();
            bus_q.delete();
        end
        @(negedge clk);
        chk("drain", 32'(exp_q.size() + bus_q.size()), 32'(0));
        chk("ready_after", 32'(ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        opcode       = '0;
        addr         = '0;
        storedata    = '0;
        avm_readdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_regwrite", 32'(regwrite), 32'(0));
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_load_opcode", 32'(load_opcode), 32'(0));
        chk("rst_errors", 32'({addr_error, bus_error}), 32'(0));
        chk("rst_strobes", 32'({avm_read, avm_write}), 32'(0));
        chk("rst_avm_address", avm_address, 32'h0);
        chk("rst_avm_be", 32'(avm_byteenable), 32'(0));
        chk("rst_avm_wd", avm_writedata, 32'h0);

        // lw with two stall cycles
        issue(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b1,
              mkb(32'h100, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'hDEADBEEF, OP_LW, 1'b1, 1'b0, 1'b0, 4, 3));
        issue(OP_LB, 32'h203, 32'h0, 32'h80112233, 0, 1'b0, 1'b1,
              mkb(32'h200, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h00000080, OP_LB, 1'b1, 1'b0, 1'b0, 2, 1));
        // sh with start held through BUS and DONE: the extra starts must be ignored
        issue(OP_SH, 32'h12, 32'h0000ABCD, 32'h0, 0, 1'b1, 1'b1,
              mkb(32'h10, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD), mk(32'h0, OP_SH, 1'b0, 1'b0, 1'b0, 2, 1));
        issue(OP_LBU, 32'h101, 32'h0, 32'h11AA2233, 0, 1'b0, 1'b1,
              mkb(32'h100, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h00000022, OP_LBU, 1'b1, 1'b0, 1'b0, 2, 1));
        issue(OP_LHU, 32'h2, 32'h0, 32'hCAFE1234, 1, 1'b0, 1'b1,
              mkb(32'h0, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h0000CAFE, OP_LHU, 1'b1, 1'b0, 1'b0, 3, 2));
        issue(OP_SB, 32'h7, 32'h123456A5, 32'h0, 0, 1'b0, 1'b1,
              mkb(32'h4, 1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5), mk(32'h0, OP_SB, 1'b0, 1'b0, 1'b0, 2, 1));
        issue(OP_SW, 32'h40, 32'h01234567, 32'h0, 3, 1'b0, 1'b1,
              mkb(32'h40, 1'b0, 1'b1, 4'b1111, 32'h01234567), mk(32'h0, OP_SW, 1'b0, 1'b0, 1'b0, 5, 4));
        issue(OP_LWL, 32'h33, 32'h0, 32'h55667788, 0, 1'b0, 1'b1,
              mkb(32'h30, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h55667788, OP_LWL, 1'b1, 1'b0, 1'b0, 2, 1));
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        issue(OP_LW, 32'h101, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b0,
              mkb(32'h0, 1'b0, 1'b0, 4'b0, 32'h0), mk(32'h0, OP_LW, 1'b0, 1'b1, 1'b0, 1, 0));
        issue(OP_LH, 32'h3, 32'h0, 32'hBEEF0001, 0, 1'b0, 1'b0,
              mkb(32'h0, 1'b0, 1'b0, 4'b0, 32'h0), mk(32'h0, OP_LH, 1'b0, 1'b1, 1'b0, 1, 0));
`else
        issue(OP_LW, 32'h101, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b1,
              mkb(32'h100, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h0BADF00D, OP_LW, 1'b1, 1'b0, 1'b0, 2, 1));
        issue(OP_LH, 32'h3, 32'h0, 32'hBEEF0001, 0, 1'b0, 1'b1,
              mkb(32'h0, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h0000BEEF, OP_LH, 1'b1, 1'b0, 1'b0, 2, 1));
`endif
        // Stuck slave: abort after four stall cycles
        issue(OP_LW, 32'h80, 32'h0, 32'h12345678, 100, 1'b0, 1'b1,
              mkb(32'h80, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h0, OP_LW, 1'b0, 1'b0, 1'b1, 5, 4));

        // Unsupported opcodes are ignored
        @(negedge clk);
        opcode = 6'b000000;
        start  = 1'b1;
        @(negedge clk);
        chk("ignored_op0_ready", 32'(ready), 32'(1));
        opcode = 6'b101010;
        @(negedge clk);
        chk("ignored_swl_ready", 32'(ready), 32'(1));
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ignored_no_strobe", 32'({avm_read, avm_write}), 32'(0));

        // Reset while the bus request is stalled
        @(negedge clk);
        wait_left  = 100;
        opcode     = OP_LW;
        addr       = 32'h60;
        start      = 1'b1;
        strobe_cnt = 0;
        bus_q.push_back(mkb(32'h60, 1'b1, 1'b0, 4'b1111, 32'h0));
        @(negedge clk);
        opcode = OP_SW;
        @(negedge clk);
        chk("busy_ready_low", 32'(ready), 32'(0));
        start   = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midbus_rst_read", 32'(avm_read), 32'(0));
        chk("midbus_rst_ready", 32'(ready), 32'(1));
        chk("midbus_rst_done", 32'(done), 32'(0));
        reset_n   = 1'b1;
        wait_left = 0;
        repeat (4) @(negedge clk);
        chk("midbus_drain", 32'(bus_q.size() + exp_q.size()), 32'(0));

        // Recovery after reset
        issue(OP_LW, 32'h8, 32'h0, 32'h13579BDF, 0, 1'b0, 1'b1,
              mkb(32'h8, 1'b1, 1'b0, 4'b1111, 32'h0), mk(32'h13579BDF, OP_LW, 1'b1, 1'b0, 1'b0, 2, 1));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
